// File: rtl/wb_arb_stage_if.sv
// Writeback arbiter bus: MEM pipeline result, LL handshake,
// register-file write bundle and status outputs.
interface wb_arb_stage_if #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int LL_DEPTH  = 4,
    parameter int CNT_BITS  = 32
);
    localparam int PW = $clog2(LL_DEPTH) + 1;

    logic                 pipe_valid;
    logic                 pipe_wr_reg;
    logic [REGNOBITS-1:0] pipe_regno;
    logic [DBITS-1:0]     pipe_data;
    logic                 pipe_halt;
    logic                 ll_valid;
    logic                 ll_ready;
    logic [REGNOBITS-1:0] ll_regno;
    logic [DBITS-1:0]     ll_data;
    logic                 rf_wr_en;
    logic [REGNOBITS-1:0] rf_wr_regno;
    logic [DBITS-1:0]     rf_wr_data;
    logic [CNT_BITS-1:0]  retire_count;
    logic [PW-1:0]        ll_pending;
    logic                 halted;

    modport master (
        output pipe_valid, pipe_wr_reg, pipe_regno,
        output pipe_data, pipe_halt,
        output ll_valid, ll_regno, ll_data,
        input  ll_ready,
        input  rf_wr_en, rf_wr_regno, rf_wr_data,
        input  retire_count, ll_pending, halted
    );

    modport slave (
        input  pipe_valid, pipe_wr_reg, pipe_regno,
        input  pipe_data, pipe_halt,
        input  ll_valid, ll_regno, ll_data,
        output ll_ready,
        output rf_wr_en, rf_wr_regno, rf_wr_data,
        output retire_count, ll_pending, halted
    );
endinterface

// File: rtl/wb_arb_stage.sv
// Writeback stage: merges MEM results and a buffered long-latency
// result stream onto one register-file write port.
module wb_arb_stage #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int LL_DEPTH  = 4,
    parameter int CNT_BITS  = 32
) (
    input logic          clk,
    input logic          reset,
    wb_arb_stage_if.slave bus
);
    localparam int AW = $clog2(LL_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL = OW'(LL_DEPTH);

    logic [REGNOBITS-1:0] fifo_regno [LL_DEPTH];
    logic [DBITS-1:0]     fifo_data  [LL_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [OW-1:0]        occ;

    logic                 en_q;
    logic [REGNOBITS-1:0] regno_q;
    logic [DBITS-1:0]     data_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic                 halt_pending;
    logic                 halted_q;

    logic                 ready;
    logic                 pipe_req;
    logic                 push;
    logic                 pop;
    logic [REGNOBITS-1:0] head_regno;
    logic [DBITS-1:0]     head_data;

    // ready comes from registered occupancy only, so a same-cycle
    // pop never opens a slot for a push
    assign ready      = (occ != FULL);
    assign pipe_req   = bus.pipe_valid && bus.pipe_wr_reg;
    assign push       = bus.ll_valid && ready;
    assign pop        = (occ != '0) && !pipe_req;
    assign head_regno = fifo_regno[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_regno[wr_ptr] <= bus.ll_regno;
            fifo_data[wr_ptr]  <= bus.ll_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                occ <= occ + OW'(1);
            else if (pop && !push)
                occ <= occ - OW'(1);
        end
    end

    // a write to register 0 still takes the port but is suppressed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            regno_q <= '0;
            data_q  <= '0;
        end else if (pipe_req) begin
            en_q    <= (bus.pipe_regno != '0);
            regno_q <= bus.pipe_regno;
            data_q  <= bus.pipe_data;
        end else if (pop) begin
            en_q    <= (head_regno != '0);
            regno_q <= head_regno;
            data_q  <= head_data;
        end else begin
            en_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            halt_pending <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            if (bus.pipe_valid)
                cnt_q <= cnt_q + CNT_BITS'(1);
            if (bus.pipe_valid && bus.pipe_halt)
                halt_pending <= 1'b1;
            if (halt_pending && occ == '0 && !en_q)
                halted_q <= 1'b1;
        end
    end

    assign bus.ll_ready     = ready;
    assign bus.rf_wr_en     = en_q;
    assign bus.rf_wr_regno  = regno_q;
    assign bus.rf_wr_data   = data_q;
    assign bus.retire_count = cnt_q;
    assign bus.ll_pending   = occ;
    assign bus.halted       = halted_q;
endmodule

// File: tb/tb_wb_arb_stage.sv
// Randomized scoreboard bench for wb_arb_stage against a
// queue-based reference model of the writeback arbitration rules.
module tb_wb_arb_stage;
    localparam int DB = 32;
    localparam int RB = 5;
    localparam int DEPTH = 4;
    localparam int CB = 4;

    typedef struct {
        int          cyc;
        logic [RB-1:0] r;
        logic [DB-1:0] d;
    } wr_t;

    typedef struct {
        logic [RB-1:0] r;
        logic [DB-1:0] d;
    } ll_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;

    wr_t expq[$];
    ll_t llq[$];
    logic [CB-1:0] m_ret = '0;
    bit   m_hp = 0;
    bit   m_halted = 0;
    bit   m_en = 0;

    wb_arb_stage_if #(.DBITS(DB), .REGNOBITS(RB),
                      .LL_DEPTH(DEPTH), .CNT_BITS(CB)) bus();

    wb_arb_stage #(.DBITS(DB), .REGNOBITS(RB),
                   .LL_DEPTH(DEPTH), .CNT_BITS(CB)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h @cyc %0d",
                     n, a, e, cyc);
        end
    endtask

    // monitor: every presented write must match the oldest expectation
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    vecs++;
                    errs++;
                    $display("FAIL missing_write: reg %0d data %0h due cyc %0d",
                             e.r, e.d, e.cyc);
                end
                if (bus.rf_wr_en) begin
                    if (expq.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL extra_write: got reg %0d data %0h cyc %0d",
                                 bus.rf_wr_regno, bus.rf_wr_data, cyc);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_cyc", 64'(cyc), 64'(e.cyc));
                        chk("wr_regno", 64'(bus.rf_wr_regno), 64'(e.r));
                        chk("wr_data", 64'(bus.rf_wr_data), 64'(e.d));
                    end
                end
            end
        end
    end

    task automatic check_state();
        chk("ll_pending", 64'(bus.ll_pending), 64'(llq.size()));
        chk("ll_ready", 64'(bus.ll_ready), 64'(llq.size() != DEPTH));
        chk("retire", 64'(bus.retire_count), 64'(m_ret));
        chk("halted", 64'(bus.halted), 64'(m_halted));
    endtask

    task automatic step(input bit pv, input bit pw,
                        input logic [RB-1:0] pr, input logic [DB-1:0] pd,
                        input bit ph, input bit lv,
                        input logic [RB-1:0] lr, input logic [DB-1:0] ld);
        int  occ0;
        bit  rdy;
        bit  en_n;
        ll_t h;
        @(negedge clk);
        check_state();
        bus.pipe_valid  = pv;
        bus.pipe_wr_reg = pw;
        bus.pipe_regno  = pr;
        bus.pipe_data   = pd;
        bus.pipe_halt   = ph;
        bus.ll_valid    = lv;
        bus.ll_regno    = lr;
        bus.ll_data     = ld;
        occ0 = llq.size();
        rdy  = (occ0 != DEPTH);
        en_n = 0;
        if (pv && pw) begin
            if (pr != 0) begin
                expq.push_back('{cyc + 1, pr, pd});
                en_n = 1;
            end
        end else if (occ0 != 0) begin
            h = llq.pop_front();
            if (h.r != 0) begin
                expq.push_back('{cyc + 1, h.r, h.d});
                en_n = 1;
            end
        end
        if (lv && rdy)
            llq.push_back('{lr, ld});
        if (m_hp && occ0 == 0 && !m_en)
            m_halted = 1;
        if (pv && ph)
            m_hp = 1;
        if (pv)
            m_ret = m_ret + 1'b1;
        m_en = en_n;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.pipe_valid = 0;
        bus.pipe_wr_reg = 0;
        bus.pipe_halt = 0;
        bus.ll_valid = 0;
        reset = 1'b1;
        #1;
        chk("rst_en", 64'(bus.rf_wr_en), 64'd0);
        chk("rst_regno", 64'(bus.rf_wr_regno), 64'd0);
        chk("rst_data", 64'(bus.rf_wr_data), 64'd0);
        chk("rst_pending", 64'(bus.ll_pending), 64'd0);
        chk("rst_ready", 64'(bus.ll_ready), 64'd1);
        chk("rst_retire", 64'(bus.retire_count), 64'd0);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        expq.delete();
        llq.delete();
        m_ret = '0;
        m_hp = 0;
        m_halted = 0;
        m_en = 0;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.pipe_valid = 0;
        bus.pipe_wr_reg = 0;
        bus.pipe_regno = '0;
        bus.pipe_data = '0;
        bus.pipe_halt = 0;
        bus.ll_valid = 0;
        bus.ll_regno = '0;
        bus.ll_data = '0;
        do_reset();

        step(1, 1, 5, 32'hDEAD, 0, 0, 0, 0);
        idle(2);
        chk("retire_one", 64'(bus.retire_count), 64'd1);

        step(0, 0, 0, 0, 0, 1, 3, 32'h11);
        idle(3);

        for (int i = 0; i < 5; i++)
            step(1, 1, RB'(20 + i), $urandom, 0, 1, RB'(10 + i), 32'h100 + i);
        step(0, 0, 0, 0, 0, 1, 14, 32'h104);
        step(0, 0, 0, 0, 0, 1, 14, 32'h104);
        idle(7);

        step(0, 0, 0, 0, 0, 1, 7, 32'h77);
        step(1, 1, 0, 32'hBAD, 0, 0, 0, 0);
        idle(3);

        step(1, 1, 1, 32'hA1, 0, 1, 8, 32'h88);
        step(1, 1, 2, 32'hA2, 0, 1, 9, 32'h99);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        idle(14);
        chk("halt_sticky", 64'(bus.halted), 64'd1);

        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 1, RB'(4 + i), $urandom, 0, 1, RB'(12 + i), $urandom);
        do_reset();
        idle(6);

        for (int i = 0; i < 17; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("retire_wrap", 64'(bus.retire_count), 64'd1);

        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int i = 0; i < 300; i++)
                step($urandom_range(0, 1), $urandom_range(0, 9) < 7,
                     RB'($urandom), $urandom,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 9) < 4 + ph,
                     RB'($urandom), $urandom);
            idle(8);
        end

        idle(2);
        chk("drain_empty", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/wb_arb_stage.md
# wb_arb_stage

Parametrised writeback stage that merges two result sources onto the single register-file write port feeding DE: the in-order MEM pipeline result and an asynchronous long-latency (LL) unit result such as a divider. LL results are buffered in an internal FIFO and drained in cycles where the pipeline does not need the port. The block also keeps the retired-instruction counter and a sticky halt indicator. It sits after the MEM latch and drives the register-write bundle consumed by DE.

## Interface
Parameters:
- DBITS, 32, data width of register values
- REGNOBITS, 5, register-number width
- LL_DEPTH, 4, LL FIFO entries; power of two, at least 2
- CNT_BITS, 32, retire counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pipe_valid  in  1  MEM-latch instruction valid this cycle; always accepted, never stalled
- pipe_wr_reg  in  1  pipeline instruction writes a register
- pipe_regno  in  REGNOBITS  pipeline destination register
- pipe_data  in  DBITS  pipeline result
- pipe_halt  in  1  pipeline instruction is a halt
- ll_valid  in  1  LL result offered
- ll_ready  out  1  LL result accepted when ll_valid && ll_ready
- ll_regno  in  REGNOBITS  LL destination register
- ll_data  in  DBITS  LL result
- rf_wr_en  out  1  registered register-file write enable
- rf_wr_regno  out  REGNOBITS  registered write register number
- rf_wr_data  out  DBITS  registered write data
- retire_count  out  CNT_BITS  count of retired pipeline instructions
- ll_pending  out  $clog2(LL_DEPTH)+1  current LL FIFO occupancy
- halted  out  1  sticky halt-complete flag

## Operation
- Pipe write request: pipe_valid && pipe_wr_reg. It has absolute priority for the port.
- LL FIFO:
  - Circular buffer with read and write pointers and an occupancy counter.
  - ll_ready = (occupancy != LL_DEPTH). It depends on registered state only, never on pipe inputs.
  - Push on ll_valid && ll_ready. Pop when occupancy != 0 and there is no pipe write request this cycle.
  - Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo LL_DEPTH.
  - No bypass: a pushed entry is poppable from the next cycle at the earliest.
- Port register, loaded every cycle:
  - On a pipe write request: {1, pipe_regno, pipe_data}.
  - Else on a pop: {1, head regno, head data}.
  - Else rf_wr_en = 0; regno and data hold their values.
- Register 0: a selected write with regno 0 still consumes the port (pipe or pop) but drives rf_wr_en = 0.
- retire_count increments by 1 on each cycle with pipe_valid, independent of pipe_wr_reg, and wraps modulo 2^CNT_BITS. LL pushes do not count.
- Halt:
  - halt_pending is set on pipe_valid && pipe_halt.
  - halted is set in the cycle after halt_pending is 1, occupancy is 0 and rf_wr_en is 0.
  - halted is sticky until reset. LL pushes are still accepted while halt_pending is 1.
- Ordering: WAW hazards between pipe and LL on the same register are excluded by the producer (DE scoreboard) and are not checked here.

## Timing
- Reset values: rf_wr_en = 0, rf_wr_regno = 0, rf_wr_data = 0, retire_count = 0, ll_pending = 0, ll_ready = 1, halted = 0, halt_pending = 0, pointers = 0.
- Reset asserted mid-operation drops FIFO contents and in-flight writes immediately, with no write emitted.
- Pipe latency: 1 cycle from pipe_valid to rf_wr_en.
- LL latency: minimum 2 cycles from the handshake to rf_wr_en (push edge, then pop edge). It grows by 1 per cycle of pipe-write contention.
- ll_pending and ll_ready reflect the update of the previous edge.
- Full FIFO with a pop in the same cycle: ll_ready is still 0 that cycle, so no push occurs. ll_ready rises the next cycle.
- Continuous pipe writes starve the LL FIFO indefinitely; this is by design.

## Test plan
- Reset, then pipe_valid=1, wr_reg=1, regno=5, data=0xDEAD for one cycle -> next cycle rf_wr_en=1, regno=5, data=0xDEAD; retire_count=1.
- LL push regno=3, data=0x11 with pipe idle -> rf_wr_en=1 with regno=3 exactly 2 cycles after the handshake; ll_pending goes 1 then 0.
- LL_DEPTH=4: push 5 LL results back-to-back while pipe writes every cycle -> ll_ready=0 after 4 pushes and the 5th waits. Stopping the pipe drains the results in push order, 1 per cycle, and ll_ready returns to 1.
- Pipe write to regno 0 and LL pop contending in the same cycle -> rf_wr_en=0 that cycle, LL entry not popped, LL write appears the following cycle.
- Halt with 2 LL entries queued and pipe idle -> halted rises the cycle after the 2nd LL write completes; halted stays 1 for 10 more cycles.
- Assert reset with 3 queued entries -> outputs return to reset values immediately and no further rf_wr_en occurs. With CNT_BITS=4, 17 pipe_valid cycles leave retire_count=1.
